// File: rtl/bcd_acc_pkg.sv
// Shared types and constants for the digit-serial BCD accumulator controller.
package bcd_acc_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] op_t;

    localparam op_t OP_DIGIT = 2'b00;
    localparam op_t OP_ADD   = 2'b01;
    localparam op_t OP_CLEAR = 2'b10;
    localparam op_t OP_READ  = 2'b11;

    localparam digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        READ = 2'd2
    } state_e;

    function automatic logic is_bcd(input digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_bank.sv
// NDIG x 4-bit digit register bank: clear, shift-in at the LSD, one indexed write and one indexed read.
// Read is combinational; priority is clear > shift > write.
module bcd_digit_bank
    import bcd_acc_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int IW   = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          shift_i,
    input  digit_t        shift_dat_i,
    input  logic          wr_i,
    input  logic [IW-1:0] wr_idx_i,
    input  digit_t        wr_dat_i,
    input  logic [IW-1:0] rd_idx_i,
    output digit_t        rd_dat_o
);

    logic [NDIG-1:0][3:0] bank_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q <= '0;
        end else if (clr_i) begin
            bank_q <= '0;
        end else if (shift_i) begin
            bank_q <= {bank_q[NDIG-2:0], shift_dat_i};
        end else if (wr_i) begin
            bank_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = bank_q[rd_idx_i];

endmodule

// File: rtl/bcd_acc_ctrl.sv
// Digit-serial BCD accumulator controller sharing one external BCD adder, LSD first.
// ADD takes exactly NDIG cycles; READ streams MSD first and holds on RD_READY low; commands only taken in IDLE.
module bcd_acc_ctrl
    import bcd_acc_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [3:0] CMD_DIGIT,
    output logic [3:0] ADD_A,
    output logic [3:0] ADD_B,
    output logic       ADD_CI,
    input  logic [3:0] ADD_S,
    input  logic       ADD_CO,
    output logic       RD_VALID,
    input  logic       RD_READY,
    output logic [3:0] RD_DIGIT,
    output logic       BUSY,
    output logic       OVF,
    output logic       ERR
);

    localparam int IW = $clog2(NDIG);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          cmd_acc;
    logic          acc_clr, acc_wr, opd_clr, opd_shift;
    digit_t        acc_dig, opd_dig;

    assign cmd_acc = CMD_VALID && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        acc_clr   = 1'b0;
        acc_wr    = 1'b0;
        opd_clr   = 1'b0;
        opd_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    case (CMD_OP)
                        OP_DIGIT: begin
                            if (is_bcd(CMD_DIGIT)) opd_shift = 1'b1;
                            else                   err_d     = 1'b1;
                        end
                        OP_ADD: begin
                            state_d = ADD;
                            idx_d   = '0;
                            carry_d = 1'b0;
                        end
                        OP_CLEAR: begin
                            acc_clr = 1'b1;
                            opd_clr = 1'b1;
                            ovf_d   = 1'b0;
                            err_d   = 1'b0;
                        end
                        default: begin
                            state_d = READ;
                            idx_d   = IDX_LAST;
                        end
                    endcase
                end
            end
            ADD: begin
                acc_wr  = 1'b1;
                carry_d = ADD_CO;
                if (idx_q == IDX_LAST) begin
                    // Carry out of the MSD is the only overflow source; it is sticky.
                    ovf_d   = ovf_q | ADD_CO;
                    opd_clr = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            READ: begin
                if (RD_READY) begin
                    if (idx_q == '0) state_d = IDLE;
                    else             idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    bcd_digit_bank #(.NDIG(NDIG), .IW(IW)) u_acc_bank (
        .clk_i       (CLK),
        .rst_n_i     (CLR_N),
        .clr_i       (acc_clr),
        .shift_i     (1'b0),
        .shift_dat_i ('0),
        .wr_i        (acc_wr),
        .wr_idx_i    (idx_q),
        .wr_dat_i    (ADD_S),
        .rd_idx_i    (idx_q),
        .rd_dat_o    (acc_dig)
    );

    bcd_digit_bank #(.NDIG(NDIG), .IW(IW)) u_opd_bank (
        .clk_i       (CLK),
        .rst_n_i     (CLR_N),
        .clr_i       (opd_clr),
        .shift_i     (opd_shift),
        .shift_dat_i (CMD_DIGIT),
        .wr_i        (1'b0),
        .wr_idx_i    ('0),
        .wr_dat_i    ('0),
        .rd_idx_i    (idx_q),
        .rd_dat_o    (opd_dig)
    );

    assign CMD_READY = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign ADD_A     = (state_q == ADD) ? acc_dig : '0;
    assign ADD_B     = (state_q == ADD) ? opd_dig : '0;
    assign ADD_CI    = (state_q == ADD) && carry_q;
    assign RD_VALID  = (state_q == READ);
    assign RD_DIGIT  = (state_q == READ) ? acc_dig : '0;
    assign OVF       = ovf_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_bcd_acc_ctrl.sv
// Bench for bcd_acc_ctrl (NDIG=4): directed scenarios then random commands against a decimal-arithmetic model.
module tb_bcd_acc_ctrl;
    import bcd_acc_pkg::*;

    localparam int NDIG = 4;
    localparam int MODV = 10000;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_OP = 2'b00;
    logic [3:0] CMD_DIGIT = 4'd0;
    logic [3:0] ADD_A, ADD_B, ADD_S;
    logic       ADD_CI, ADD_CO;
    logic       RD_VALID;
    logic       RD_READY = 1'b0;
    logic [3:0] RD_DIGIT;
    logic       BUSY, OVF, ERR;

    int checks = 0;
    int errors = 0;

    int acc_m = 0;
    int opd_m = 0;
    bit ovf_m = 1'b0;
    bit err_m = 1'b0;
    int p10 [NDIG] = '{1, 10, 100, 1000};
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bcd_acc_ctrl #(.NDIG(NDIG)) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_DIGIT (CMD_DIGIT),
        .ADD_A     (ADD_A),
        .ADD_B     (ADD_B),
        .ADD_CI    (ADD_CI),
        .ADD_S     (ADD_S),
        .ADD_CO    (ADD_CO),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .RD_DIGIT  (RD_DIGIT),
        .BUSY      (BUSY),
        .OVF       (OVF),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-digit BCD adder on the shared adder port.
    logic [4:0] add_tot;
    assign add_tot = 5'(ADD_A) + 5'(ADD_B) + 5'(ADD_CI);
    assign ADD_CO  = (add_tot > 5'd9);
    assign ADD_S   = ADD_CO ? 4'(add_tot - 5'd10) : add_tot[3:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags();
        chk("ovf", OVF, ovf_m);
        chk("err", ERR, err_m);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_add_a", ADD_A, 0);
        chk("rst_add_b", ADD_B, 0);
        chk("rst_add_ci", ADD_CI, 0);
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_rd_digit", RD_DIGIT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cmd_ready", CMD_READY, 1);
        chk("rst_ovf", OVF, 0);
        chk("rst_err", ERR, 0);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_ready_wait", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DIGIT = d;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic do_digit(input logic [3:0] d);
        send(OP_DIGIT, d);
        if (d <= 4'd9) opd_m = (opd_m * 10 + int'(d)) % MODV;
        else           err_m = 1'b1;
        @(negedge CLK);
        chk_flags();
    endtask

    task automatic do_clear();
        send(OP_CLEAR, 4'd0);
        acc_m = 0;
        opd_m = 0;
        ovf_m = 1'b0;
        err_m = 1'b0;
        @(negedge CLK);
        chk_flags();
    endtask

    // junk: hold a non-BCD DIGIT command on the bus while busy; it must be ignored.
    task automatic do_add(input bit junk);
        int s;
        send(OP_ADD, 4'd0);
        if (junk) begin
            CMD_VALID = 1'b1;
            CMD_OP    = OP_DIGIT;
            CMD_DIGIT = 4'hA;
        end
        for (int i = 0; i < NDIG; i++) begin
            @(negedge CLK);
            chk("add_busy", BUSY, 1);
            chk("add_cmd_ready", CMD_READY, 0);
            chk("add_a", ADD_A, (acc_m / p10[i]) % 10);
            chk("add_b", ADD_B, (opd_m / p10[i]) % 10);
            chk("add_ci", ADD_CI, ((acc_m % p10[i]) + (opd_m % p10[i])) >= p10[i]);
            if (i == NDIG - 1) CMD_VALID = 1'b0;
        end
        @(negedge CLK);
        chk("add_done_ready", CMD_READY, 1);
        chk("add_done_busy", BUSY, 0);
        chk("add_idle_a", ADD_A, 0);
        s = acc_m + opd_m;
        if (s >= MODV) ovf_m = 1'b1;
        acc_m = s % MODV;
        opd_m = 0;
        chk_flags();
    endtask

    task automatic do_read(input bit rnd);
        int j, k, got;
        bit rdy;
        j   = NDIG - 1;
        k   = 0;
        got = 0;
        send(OP_READ, 4'd0);
        while (j >= 0 && k < 200) begin
            @(negedge CLK);
            chk("rd_valid", RD_VALID, 1);
            chk("rd_digit", RD_DIGIT, (acc_m / p10[j]) % 10);
            rdy = rnd ? 1'($urandom_range(0, 1)) : pat[k % 7];
            RD_READY = rdy;
            if (rdy) begin
                got = got * 10 + int'(RD_DIGIT);
                j--;
            end
            k++;
        end
        chk("rd_timeout", j, -1);
        @(negedge CLK);
        RD_READY = 1'b0;
        chk("rd_valid_end", RD_VALID, 0);
        chk("rd_ready_end", CMD_READY, 1);
        chk("rd_value", got, acc_m);
    endtask

    initial begin
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge CLK);
        CLR_N = 1'b1;
        @(negedge CLK);
        chk_reset_outputs();

        // 0 + 1234
        do_digit(4'd1); do_digit(4'd2); do_digit(4'd3); do_digit(4'd4);
        do_add(1'b0);
        do_read(1'b1);

        // 1234 + 8766 wraps to 0000 with overflow; overflow is sticky
        do_digit(4'd8); do_digit(4'd7); do_digit(4'd6); do_digit(4'd6);
        do_add(1'b0);
        do_read(1'b1);
        do_digit(4'd1);
        do_add(1'b0);
        do_clear();

        // 0999 + 0001 ripples a carry through three digits
        do_digit(4'd9); do_digit(4'd9); do_digit(4'd9);
        do_add(1'b0);
        do_digit(4'd1);
        do_add(1'b0);

        // Non-BCD digit while busy is ignored, then a real one in IDLE sets ERR
        do_add(1'b1);
        do_digit(4'd1); do_digit(4'd2); do_digit(4'hA);

        // Stalled MSD-first read of 1000
        do_read(1'b0);
        do_add(1'b0);

        // Reset in the middle of an ADD
        do_clear();
        repeat (4) do_digit(4'd5);
        do_add(1'b0);
        repeat (4) do_digit(4'd4);
        send(OP_ADD, 4'd0);
        repeat (3) @(negedge CLK);
        chk("mid_add_busy", BUSY, 1);
        chk("mid_add_a", ADD_A, 5);
        CLR_N = 1'b0;
        #1;
        chk_reset_outputs();
        acc_m = 0; opd_m = 0; ovf_m = 1'b0; err_m = 1'b0;
        @(negedge CLK);
        CLR_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", CMD_READY, 1);
        do_read(1'b0);
        do_add(1'b0);

        // Random command mix
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4)      do_digit(4'($urandom_range(0, 11)));
            else if (r <= 6) do_add(1'($urandom_range(0, 1)));
            else if (r <= 8) do_read(1'b1);
            else             do_clear();
        end
        do_read(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_acc_ctrl.md
Name: bcd_acc_ctrl

Overview:
- Digit-serial controller for an NDIG-digit BCD accumulator.
- Owns the accumulator and operand digit banks. Time-shares one external 4-bit BCD adder across all digits, LSD first, with a carry flip-flop between digits.
- Accepts commands from the RS232 command decoder: shift in a digit, add, clear, read.
- Streams the accumulator back MSD first for transmission.

Parameters:
- NDIG, 4: number of BCD digits in accumulator and operand (2..8).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command strobe.
- CMD_READY  out  1  controller accepts a command this cycle.
- CMD_OP  in  2  opcode: 00 DIGIT, 01 ADD, 10 CLEAR, 11 READ.
- CMD_DIGIT  in  4  BCD digit for the DIGIT op.
- ADD_A  out  4  adder operand A (accumulator digit).
- ADD_B  out  4  adder operand B (operand digit).
- ADD_CI  out  1  adder carry in.
- ADD_S  in  4  adder BCD sum (combinational from ADD_A/ADD_B/ADD_CI).
- ADD_CO  in  1  adder carry out.
- RD_VALID  out  1  RD_DIGIT is valid.
- RD_READY  in  1  consumer takes RD_DIGIT.
- RD_DIGIT  out  4  accumulator digit, MSD first.
- BUSY  out  1  high in ADD or READ.
- OVF  out  1  sticky: set on carry out of the MSD.
- ERR  out  1  sticky: set on a non-BCD digit.

Behaviour:
- Reset: CLR_N low asynchronously forces state IDLE and clears all digit banks, carry, index, OVF, ERR, RD_VALID and BUSY. ADD_A, ADD_B, ADD_CI, RD_DIGIT all read 0. Reset mid-ADD or mid-READ aborts the operation; no partial write-back survives.
- Handshake: CMD_READY = 1 only in IDLE. A command is accepted on a cycle where CMD_VALID and CMD_READY are both 1. CMD_VALID in any other state is ignored, not queued.
- States: IDLE, ADD, READ.
- DIGIT (IDLE, 1 cycle):
  - If CMD_DIGIT <= 9: operand shifts up one digit, CMD_DIGIT becomes the LSD, the old MSD is discarded.
  - If CMD_DIGIT > 9: operand is unchanged and ERR is set.
- CLEAR (IDLE, 1 cycle): accumulator, operand, OVF and ERR go to 0.
- ADD (IDLE -> ADD):
  - Index i = 0, carry = 0.
  - Each ADD cycle drives ADD_A = acc[i], ADD_B = opd[i], ADD_CI = carry.
  - On the edge: acc[i] <= ADD_S, carry <= ADD_CO, i <= i+1.
  - After i = NDIG-1: if ADD_CO = 1, OVF is set. Operand is cleared and the FSM returns to IDLE.
  - Latency: exactly NDIG cycles in ADD. CMD_READY is high again on cycle NDIG+1 after acceptance.
  - Result is acc + opd mod 10^NDIG.
- Adder outputs: ADD_A/ADD_B/ADD_CI = 0 outside ADD.
- READ (IDLE -> READ):
  - Index j = NDIG-1. RD_VALID = 1, RD_DIGIT = acc[j].
  - On RD_VALID & RD_READY: j decrements. After j = 0 is taken, RD_VALID drops and the FSM returns to IDLE.
  - While RD_READY = 0, RD_DIGIT and RD_VALID hold stable.
  - The accumulator is not modified by READ.
- BUSY = (state != IDLE).
- OVF and ERR are cleared only by CLEAR or reset. ADD never clears them.
- The index counter width is the minimum for NDIG-1. It never wraps past NDIG-1 within an operation.

Decomposition:
- Package bcd_acc_pkg:
  - opcode constants OP_DIGIT / OP_ADD / OP_CLEAR / OP_READ
  - state encoding IDLE / ADD / READ
  - BCD_MAX = 9
  - digit type (4 bits)
- One sub-module, bcd_digit_bank: an NDIG x 4 register bank with async clear, sync clear, shift-in-LSD, and indexed write/read ports. It is instantiated twice: accumulator and operand.
- The adder stays external, so the controller can share it with other users.

Test Plan:
The bench uses NDIG = 4 and a behavioural 4-bit BCD adder on the ADD_* ports.
- Reset, DIGIT 1,2,3,4, ADD -> ADD_A/ADD_B pairs (0,4)(0,3)(0,2)(0,1); CMD_READY low exactly 4 cycles; acc = 1234; operand = 0000; OVF = 0.
- acc = 1234, DIGIT 8,7,6,6, ADD -> acc = 0000; ADD_CI sequence 0,1,1,1; OVF = 1; OVF stays 1 after a further ADD of 0001; CLEAR -> OVF = 0.
- acc = 0999, DIGIT 1, ADD -> acc = 1000; ADD_CI sequence 0,1,1,1.
- DIGIT 0xA with operand 0012 -> operand stays 0012, ERR = 1. DIGIT 0xA sent while BUSY -> ignored, ERR unchanged.
- acc = 1000, READ with RD_READY pattern 1,0,0,1,1,0,1 -> digits delivered in order 1,0,0,0; RD_DIGIT stable during stalls; RD_VALID falls after the 4th transfer; acc unchanged.
- acc = 5555, operand 4444, ADD, CLR_N low during the 3rd ADD cycle -> all outputs 0 immediately. After release: IDLE, CMD_READY = 1, READ returns 0,0,0,0.
